decoder: RTL and testbench



---
 rtl/decoder.sv | 116 +++++++++++
 tb/tb_decoder.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/decoder.sv
// decoder: APCPU instruction decode stage.
// Registers one 32-bit instruction per clock and splits it into an ALU code,
// three register-file selects and a 24-bit immediate/data word, with the
// operand format chosen by APSelBus. One cycle of latency, no other state.
// Optional feature: define DECODER_SIGN_EXT_EN to enable mode 4
// (imm16 sign-extended); otherwise mode 4 decodes as a reserved NOP.
module decoder (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] InstructionBus,
  input  logic [2:0]  APSelBus,
  output logic [7:0]  AluCode,
  output logic [23:0] DecoderData,
  output logic [2:0]  RegSelX,
  output logic [2:0]  RegSelY,
  output logic [2:0]  RegSelZ
);

  localparam logic [2:0] MODE_REG   = 3'd0;
  localparam logic [2:0] MODE_IMM8  = 3'd1;
  localparam logic [2:0] MODE_IMM16 = 3'd2;
  localparam logic [2:0] MODE_IMM24 = 3'd3;
`ifdef DECODER_SIGN_EXT_EN
  localparam logic [2:0] MODE_SIMM16 = 3'd4;
`endif

  // Instruction fields
  logic [7:0]  w_op;
  logic [2:0]  w_fx;
  logic [2:0]  w_fy;
  logic [2:0]  w_fz;

  assign w_op = InstructionBus[31:24];
  assign w_fx = InstructionBus[2:0];
  assign w_fy = InstructionBus[10:8];
  assign w_fz = InstructionBus[18:16];

  // Decoded (pre-register) values
  logic [7:0]  w_alu_code;
  logic [23:0] w_data;
  logic [2:0]  w_sel_x;
  logic [2:0]  w_sel_y;
  logic [2:0]  w_sel_z;

  // Output registers
  logic [7:0]  r_alu_code;
  logic [23:0] r_data;
  logic [2:0]  r_sel_x;
  logic [2:0]  r_sel_y;
  logic [2:0]  r_sel_z;

  // Select the operand format for the current mode; unlisted modes are NOPs
  always_comb begin
    w_alu_code = 8'h00;
    w_data     = 24'h0;
    w_sel_x    = 3'h0;
    w_sel_y    = 3'h0;
    w_sel_z    = 3'h0;
    case (APSelBus)
      MODE_REG: begin
        w_alu_code = w_op;
        w_sel_x    = w_fx;
        w_sel_y    = w_fy;
        w_sel_z    = w_fz;
      end
      MODE_IMM8: begin
        w_alu_code = w_op;
        w_sel_y    = w_fy;
        w_sel_z    = w_fz;
        w_data     = {16'h0, InstructionBus[7:0]};
      end
      MODE_IMM16: begin
        w_alu_code = w_op;
        w_sel_z    = w_fz;
        w_data     = {8'h0, InstructionBus[15:0]};
      end
      MODE_IMM24: begin
        w_alu_code = w_op;
        w_data     = InstructionBus[23:0];
      end
`ifdef DECODER_SIGN_EXT_EN
      MODE_SIMM16: begin
        w_alu_code = w_op;
        w_sel_z    = w_fz;
        w_data     = {{8{InstructionBus[15]}}, InstructionBus[15:0]};
      end
`endif
      default: begin
      end
    endcase
  end

  // Capture the decode each edge; reset clears everything and wins over decode
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_alu_code <= 8'h00;
      r_data     <= 24'h0;
      r_sel_x    <= 3'h0;
      r_sel_y    <= 3'h0;
      r_sel_z    <= 3'h0;
    end else begin
      r_alu_code <= w_alu_code;
      r_data     <= w_data;
      r_sel_x    <= w_sel_x;
      r_sel_y    <= w_sel_y;
      r_sel_z    <= w_sel_z;
    end
  end

  assign AluCode     = r_alu_code;
  assign DecoderData = r_data;
  assign RegSelX     = r_sel_x;
  assign RegSelY     = r_sel_y;
  assign RegSelZ     = r_sel_z;

endmodule

// File: tb/tb_decoder.sv
// tb_decoder: randomized and directed bench for decoder, checked every cycle
// against a behavioural model, plus literal expectations from hand decoding.
module tb_decoder;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] InstructionBus;
  logic [2:0]  APSelBus;
  logic [7:0]  AluCode;
  logic [23:0] DecoderData;
  logic [2:0]  RegSelX;
  logic [2:0]  RegSelY;
  logic [2:0]  RegSelZ;

  int n_checks = 0;
  int n_fail   = 0;

  logic [40:0] exp_q;
  logic        exp_valid = 1'b0;

  decoder dut (
    .clk            (clk),
    .rst            (rst),
    .InstructionBus (InstructionBus),
    .APSelBus       (APSelBus),
    .AluCode        (AluCode),
    .DecoderData    (DecoderData),
    .RegSelX        (RegSelX),
    .RegSelY        (RegSelY),
    .RegSelZ        (RegSelZ)
  );

  always #5 clk = ~clk;

  function automatic logic [40:0] pk(input int unsigned op, input int unsigned x,
                                     input int unsigned y, input int unsigned z,
                                     input int unsigned d);
    return {8'(op), 3'(x), 3'(y), 3'(z), 24'(d)};
  endfunction

  // Reference: what the outputs must be after an edge that saw these inputs
  function automatic logic [40:0] model(input logic r, input logic [31:0] i,
                                        input logic [2:0] m);
    int unsigned w, op, fx, fy, fz, v;
    w  = i;
    op = w / 32'h0100_0000;
    fx = w % 8;
    fy = (w / 256) % 8;
    fz = (w / 65536) % 8;
    if (r !== 1'b1) return pk(0, 0, 0, 0, 0);
    case (m)
      3'd0: return pk(op, fx, fy, fz, 0);
      3'd1: return pk(op, 0, fy, fz, w % 256);
      3'd2: return pk(op, 0, 0, fz, w % 65536);
      3'd3: return pk(op, 0, 0, 0, w % 32'h0100_0000);
`ifdef DECODER_SIGN_EXT_EN
      3'd4: begin
        v = w % 65536;
        if (v >= 32768) v = v + 32'h00FF_0000;
        return pk(op, 0, 0, fz, v);
      end
`endif
      default: return pk(0, 0, 0, 0, 0);
    endcase
  endfunction

  function automatic logic [40:0] dut_out();
    return {AluCode, RegSelX, RegSelY, RegSelZ, DecoderData};
  endfunction

  task automatic chk(input string name, input logic [40:0] act, input logic [40:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got alu=%h x=%0d y=%0d z=%0d data=%h, expected alu=%h x=%0d y=%0d z=%0d data=%h",
               name, act[40:33], act[32:30], act[29:27], act[26:24], act[23:0],
               exp[40:33], exp[32:30], exp[29:27], exp[26:24], exp[23:0]);
    end
  endtask

  // Model tracks the inputs sampled at every rising edge
  always @(posedge clk) begin
    exp_q     <= model(rst, InstructionBus, APSelBus);
    exp_valid <= 1'b1;
  end

  // Compare every cycle, on the falling edge
  always @(negedge clk) begin
    if (exp_valid) chk("cycle_compare", dut_out(), exp_q);
  end

  // Drive one set of inputs and step past the next rising edge
  task automatic cyc(input logic r, input logic [31:0] i, input logic [2:0] m);
    rst            = r;
    InstructionBus = i;
    APSelBus       = m;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [40:0] z0;
    z0 = pk(0, 0, 0, 0, 0);
    rst = 1'b0;
    InstructionBus = 32'h0;
    APSelBus = 3'd0;

    // Reset held for three edges
    for (int k = 0; k < 3; k++) begin
      cyc(1'b0, 32'h01129403, 3'd0);
      chk("reset_hold", dut_out(), z0);
    end
    cyc(1'b1, 32'h01129403, 3'd0);
    chk("reset_release", dut_out(), pk(8'h01, 3, 4, 2, 0));

    // Register mode, alternating words
    cyc(1'b1, 32'h00003202, 3'd0);
    chk("reg_mode_a", dut_out(), pk(8'h00, 2, 2, 0, 0));
    cyc(1'b1, 32'h01129403, 3'd0);
    chk("reg_mode_b", dut_out(), pk(8'h01, 3, 4, 2, 0));
    // Mid-cycle input change must not show until the next edge
    InstructionBus = 32'h00003202;
    #3;
    chk("hold_between_edges", dut_out(), pk(8'h01, 3, 4, 2, 0));

    // Immediate modes
    cyc(1'b1, 32'h01129403, 3'd1);
    chk("imm8", dut_out(), pk(8'h01, 0, 4, 2, 24'h000003));
    cyc(1'b1, 32'h01129403, 3'd2);
    chk("imm16", dut_out(), pk(8'h01, 0, 0, 2, 24'h009403));
    cyc(1'b1, 32'h01129403, 3'd3);
    chk("imm24", dut_out(), pk(8'h01, 0, 0, 0, 24'h129403));

    // Sign extension (or reserved when the feature is off)
    cyc(1'b1, 32'h01129403, 3'd4);
`ifdef DECODER_SIGN_EXT_EN
    chk("simm16_neg", dut_out(), pk(8'h01, 0, 0, 2, 24'hFF9403));
`else
    chk("mode4_reserved", dut_out(), z0);
`endif
    cyc(1'b1, 32'h00003202, 3'd4);
`ifdef DECODER_SIGN_EXT_EN
    chk("simm16_pos", dut_out(), pk(8'h00, 0, 0, 0, 24'h003202));
`else
    chk("mode4_reserved_b", dut_out(), z0);
`endif

    // Reserved modes
    for (int m = 5; m < 8; m++) begin
      cyc(1'b1, 32'hFFFFFFFF, 3'(m));
      chk("reserved_mode", dut_out(), z0);
    end

    // Reset mid-stream
    cyc(1'b1, 32'h01129403, 3'd0);
    chk("stream_before_reset", dut_out(), pk(8'h01, 3, 4, 2, 0));
    cyc(1'b0, 32'h01129403, 3'd0);
    chk("midstream_reset", dut_out(), z0);
    cyc(1'b1, 32'h01129403, 3'd0);
    chk("after_midstream_reset", dut_out(), pk(8'h01, 3, 4, 2, 0));

    // Randomized traffic, occasional reset, checked by the compare process
    for (int k = 0; k < 600; k++) begin
      cyc(($urandom_range(0, 19) != 0), $urandom, 3'($urandom_range(0, 7)));
    end

    @(negedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion before 200000");
    $fatal(1);
  end

endmodule
